// File: rtl/veda_ram_2r1w_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | veda_ram_2r1w_if                                                     |
// | Write port, two read ports and status strobes of veda_ram_2r1w.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface veda_ram_2r1w_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd0_en;
  logic [ADDR_W-1:0] rd0_addr;
  logic [DATA_W-1:0] rd0_data;
  logic              rd0_valid;
  logic              rd1_en;
  logic [ADDR_W-1:0] rd1_addr;
  logic [DATA_W-1:0] rd1_data;
  logic              rd1_valid;
  logic              addr_err;
  logic              par_err;

  modport master (
    input  ready, rd0_data, rd0_valid, rd1_data, rd1_valid, addr_err, par_err,
    output wr_en, wr_addr, wr_data, rd0_en, rd0_addr, rd1_en, rd1_addr
  );

  modport slave (
    output ready, rd0_data, rd0_valid, rd1_data, rd1_valid, addr_err, par_err,
    input  wr_en, wr_addr, wr_data, rd0_en, rd0_addr, rd1_en, rd1_addr
  );
endinterface
`default_nettype wire

// File: rtl/veda_ram_2r1w.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | veda_ram_2r1w                                                        |
// | 1W/2R RAM, registered reads, write-first bypass, post-reset clear.   |
// | Optional per-word even parity: define VEDA_PARITY_EN.                |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module veda_ram_2r1w #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 5,
  parameter int                DEPTH    = 32,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  wire logic      clk,
  input  wire logic      rst,
  veda_ram_2r1w_if.slave bus
);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [ADDR_W:0]   C_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] C_LAST  = ADDR_W'(DEPTH-1);

  logic [DATA_W-1:0] mem [DEPTH];
`ifdef VEDA_PARITY_EN
  logic [DEPTH-1:0]  par_mem;
`endif

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] init_ptr_q, init_ptr_d;
  logic              ready_q, ready_d;
  logic [DATA_W-1:0] rd_data_q [2];
  logic [DATA_W-1:0] rd_data_d [2];
  logic [1:0]        rd_valid_q, rd_valid_d;
  logic              addr_err_q, addr_err_d;
  logic              par_err_q, par_err_d;

  logic              w_wr_acc, w_wr_in, w_wr_do;
  logic [1:0]        w_rd_en;
  logic [ADDR_W-1:0] w_rd_addr [2];
  logic [1:0]        w_rd_in;
  logic [ADDR_W-1:0] w_rd_idx [2];

  assign w_rd_en      = {bus.rd1_en, bus.rd0_en};
  assign w_rd_addr[0] = bus.rd0_addr;
  assign w_rd_addr[1] = bus.rd1_addr;

  assign w_wr_acc = bus.wr_en & ready_q;
  assign w_wr_in  = {1'b0, bus.wr_addr} < C_DEPTH;
  assign w_wr_do  = w_wr_acc & w_wr_in;

  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    case (state_q)
      ST_INIT: begin
        init_ptr_d = init_ptr_q + 1'b1;
        if (init_ptr_q == C_LAST) begin
          state_d    = ST_RUN;
          init_ptr_d = '0;
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
    ready_d = (state_d == ST_RUN);
  end

  // Out-of-range reads index word 0 internally but always return zero.
  always_comb begin
    addr_err_d = w_wr_acc & ~w_wr_in;
    par_err_d  = 1'b0;
    rd_valid_d = '0;
    for (int k = 0; k < 2; k++) begin
      w_rd_in[k]   = {1'b0, w_rd_addr[k]} < C_DEPTH;
      w_rd_idx[k]  = w_rd_in[k] ? w_rd_addr[k] : '0;
      rd_data_d[k] = rd_data_q[k];
      if (w_rd_en[k] && ready_q) begin
        rd_valid_d[k] = 1'b1;
        if (!w_rd_in[k]) begin
          rd_data_d[k] = '0;
          addr_err_d   = 1'b1;
        end else if (w_wr_do && (bus.wr_addr == w_rd_addr[k])) begin
          rd_data_d[k] = bus.wr_data;
        end else begin
          rd_data_d[k] = mem[w_rd_idx[k]];
`ifdef VEDA_PARITY_EN
          if (par_mem[w_rd_idx[k]] != ^mem[w_rd_idx[k]]) begin
            par_err_d = 1'b1;
          end
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_INIT;
      init_ptr_q   <= '0;
      ready_q      <= 1'b0;
      rd_data_q[0] <= '0;
      rd_data_q[1] <= '0;
      rd_valid_q   <= '0;
      addr_err_q   <= 1'b0;
      par_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_ptr_q   <= init_ptr_d;
      ready_q      <= ready_d;
      rd_data_q[0] <= rd_data_d[0];
      rd_data_q[1] <= rd_data_d[1];
      rd_valid_q   <= rd_valid_d;
      addr_err_q   <= addr_err_d;
      par_err_q    <= par_err_d;
    end
  end

  // The array has no reset; the INIT sweep provides the known contents.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      mem[init_ptr_q] <= INIT_VAL;
    end else if (w_wr_do) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

`ifdef VEDA_PARITY_EN
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      par_mem[init_ptr_q] <= ^INIT_VAL;
    end else if (w_wr_do) begin
      par_mem[bus.wr_addr] <= ^bus.wr_data;
    end
  end
`endif

  assign bus.ready     = ready_q;
  assign bus.rd0_data  = rd_data_q[0];
  assign bus.rd0_valid = rd_valid_q[0];
  assign bus.rd1_data  = rd_data_q[1];
  assign bus.rd1_valid = rd_valid_q[1];
  assign bus.addr_err  = addr_err_q;
  assign bus.par_err   = par_err_q;

endmodule
`default_nettype wire

// File: tb/tb_veda_ram_2r1w.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_veda_ram_2r1w                                                     |
// | Scoreboard bench: DEPTH=32 and DEPTH=20 instances on one clock.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_veda_ram_2r1w;

  typedef struct {
    logic [31:0] data;
    int          cyc;
    logic        perr;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc_n = 0;
  int   total = 0;
  int   bad   = 0;

  // Queue index: 0/1 = DEPTH-32 ports, 2/3 = DEPTH-20 ports
  exp_t sbq [4][$];
  int   errq [2][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  veda_ram_2r1w_if #(.DATA_W(32), .ADDR_W(5)) b32 ();
  veda_ram_2r1w_if #(.DATA_W(32), .ADDR_W(5)) b20 ();

  veda_ram_2r1w #(.DATA_W(32), .ADDR_W(5), .DEPTH(32), .INIT_VAL(32'h0)) dut32 (
    .clk(clk), .rst(rst), .bus(b32)
  );
  veda_ram_2r1w #(.DATA_W(32), .ADDR_W(5), .DEPTH(20), .INIT_VAL(32'h0)) dut20 (
    .clk(clk), .rst(rst), .bus(b20)
  );

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h cyc=%0d", n, act, exp, cyc_n);
    end
  endtask

  task automatic mon_port(input int k, input logic valid, input logic [31:0] data,
                          output logic pe);
    exp_t e;
    pe = 1'b0;
    while (sbq[k].size() > 0 && sbq[k][0].cyc < cyc_n) begin
      total++; bad++;
      $display("FAIL rd_missing q=%0d act=none exp_cyc=%0d now=%0d", k, sbq[k][0].cyc, cyc_n);
      void'(sbq[k].pop_front());
    end
    if (valid) begin
      total++;
      if (sbq[k].size() == 0 || sbq[k][0].cyc != cyc_n) begin
        bad++;
        $display("FAIL rd_unexpected q=%0d act=valid exp=idle cyc=%0d", k, cyc_n);
      end else begin
        e = sbq[k].pop_front();
        pe = e.perr;
        if (data !== e.data) begin
          bad++;
          $display("FAIL rd_data q=%0d act=%0h exp=%0h cyc=%0d", k, data, e.data, cyc_n);
        end
      end
    end
  endtask

  task automatic mon_err(input int d, input logic err);
    while (errq[d].size() > 0 && errq[d][0] < cyc_n) begin
      total++; bad++;
      $display("FAIL addr_err_missing dut=%0d act=0 exp=1 cyc=%0d", d, errq[d][0]);
      void'(errq[d].pop_front());
    end
    if (err) begin
      total++;
      if (errq[d].size() > 0 && errq[d][0] == cyc_n) void'(errq[d].pop_front());
      else begin
        bad++;
        $display("FAIL addr_err_spurious dut=%0d act=1 exp=0 cyc=%0d", d, cyc_n);
      end
    end
  endtask

  task automatic mon_par(input string n, input logic any_valid, input logic par, input logic exp);
    if (any_valid) chk(n, {31'd0, par}, {31'd0, exp});
    else if (par) chk(n, {31'd0, par}, 32'd0);
  endtask

  always @(negedge clk) begin
    logic p0, p1, p2, p3;
    mon_port(0, b32.rd0_valid, b32.rd0_data, p0);
    mon_port(1, b32.rd1_valid, b32.rd1_data, p1);
    mon_port(2, b20.rd0_valid, b20.rd0_data, p2);
    mon_port(3, b20.rd1_valid, b20.rd1_data, p3);
    mon_par("par_err32", b32.rd0_valid | b32.rd1_valid, b32.par_err, p0 | p1);
    mon_par("par_err20", b20.rd0_valid | b20.rd1_valid, b20.par_err, p2 | p3);
    mon_err(0, b32.addr_err);
    mon_err(1, b20.addr_err);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    b32.wr_en = 0; b32.rd0_en = 0; b32.rd1_en = 0;
    b20.wr_en = 0; b20.rd0_en = 0; b20.rd1_en = 0;
  endtask

  task automatic push_err(input int d);
    if (errq[d].size() == 0 || errq[d][errq[d].size()-1] != cyc_n + 1) errq[d].push_back(cyc_n + 1);
  endtask

  task automatic wr32(input int a, input logic [31:0] d);
    b32.wr_en = 1; b32.wr_addr = 5'(a); b32.wr_data = d;
  endtask

  task automatic rd32(input int p, input int a, input logic [31:0] d, input logic pe);
    if (p == 0) begin b32.rd0_en = 1; b32.rd0_addr = 5'(a); end
    else        begin b32.rd1_en = 1; b32.rd1_addr = 5'(a); end
    sbq[p].push_back('{data: d, cyc: cyc_n + 1, perr: pe});
  endtask

  task automatic wr20(input int a, input logic [31:0] d);
    b20.wr_en = 1; b20.wr_addr = 5'(a); b20.wr_data = d;
    if (a >= 20) push_err(1);
  endtask

  task automatic rd20(input int p, input int a, input logic [31:0] d);
    if (p == 0) begin b20.rd0_en = 1; b20.rd0_addr = 5'(a); end
    else        begin b20.rd1_en = 1; b20.rd1_addr = 5'(a); end
    sbq[2+p].push_back('{data: d, cyc: cyc_n + 1, perr: 1'b0});
    if (a >= 20) push_err(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    b32.wr_addr = '0; b32.wr_data = '0; b32.rd0_addr = '0; b32.rd1_addr = '0;
    b20.wr_addr = '0; b20.wr_data = '0; b20.rd0_addr = '0; b20.rd1_addr = '0;
    idle();
    repeat (3) tick();
    chk("rst_ready",    {31'd0, b32.ready},     32'd0);
    chk("rst_rd0_valid",{31'd0, b32.rd0_valid}, 32'd0);
    chk("rst_rd1_valid",{31'd0, b32.rd1_valid}, 32'd0);
    chk("rst_rd0_data", b32.rd0_data,           32'd0);
    chk("rst_rd1_data", b32.rd1_data,           32'd0);
    chk("rst_addr_err", {31'd0, b32.addr_err},  32'd0);
    chk("rst_par_err",  {31'd0, b32.par_err},   32'd0);

    rst = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      tick();
      chk("ready32_init", {31'd0, b32.ready}, (i == 32) ? 32'd1 : 32'd0);
      chk("ready20_init", {31'd0, b20.ready}, (i >= 20) ? 32'd1 : 32'd0);
    end

    // Full sweep back-to-back on both ports: every word cleared
    for (int i = 0; i < 32; i++) begin
      rd32(0, i, 32'd0, 1'b0);
      rd32(1, 31 - i, 32'd0, 1'b0);
      tick(); idle();
    end

    wr32(0, 32'd231); tick(); idle();
    wr32(1, 32'd423); tick(); idle();
    rd32(0, 0, 32'd231, 1'b0); rd32(1, 1, 32'd423, 1'b0); tick(); idle();

    wr32(5, 32'hDEADBEEF); rd32(0, 5, 32'hDEADBEEF, 1'b0); rd32(1, 5, 32'hDEADBEEF, 1'b0);
    tick(); idle();
    rd32(0, 5, 32'hDEADBEEF, 1'b0); wr32(6, 32'h11); rd32(1, 0, 32'd231, 1'b0);
    tick(); idle();
    rd32(0, 6, 32'h11, 1'b0); tick(); idle();

    // DEPTH=20: out-of-range accesses and the last valid word
    wr20(25, 32'd7); tick(); idle();
    rd20(0, 25, 32'd0); tick(); idle();
    rd20(0, 5, 32'd0); rd20(1, 9, 32'd0); tick(); idle();
    wr20(19, 32'h13); tick(); idle();
    rd20(0, 19, 32'h13); rd20(1, 20, 32'd0); tick(); idle();
    wr20(30, 32'd5); rd20(0, 30, 32'd0); tick(); idle();
    rd20(0, 30, 32'd0); rd20(1, 10, 32'd0); tick(); idle();
    repeat (3) tick();

    // Reset mid-RUN, writes during INIT ignored
    wr32(3, 32'd99); tick(); idle();
    rd32(0, 3, 32'd99, 1'b0); tick(); idle();
    repeat (2) tick();
    rst = 1'b0;
    #1;
    chk("ready32_async_rst", {31'd0, b32.ready}, 32'd0);
    tick();
    rst = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      wr32(3, 32'd55);
      tick();
      chk("ready32_reinit", {31'd0, b32.ready}, (i == 32) ? 32'd1 : 32'd0);
    end
    idle();
    rd32(0, 3, 32'd0, 1'b0); rd32(1, 0, 32'd0, 1'b0); tick(); idle();
    rd32(0, 5, 32'd0, 1'b0); tick(); idle();

`ifdef VEDA_PARITY_EN
    dut32.mem[2] = dut32.mem[2] ^ 32'd1;
    rd32(0, 2, 32'd1, 1'b1); rd32(1, 4, 32'd0, 1'b0); tick(); idle();
    rd32(0, 4, 32'd0, 1'b0); tick(); idle();
`endif

    repeat (4) tick();
    for (int k = 0; k < 4; k++) chk("sb_drained", sbq[k].size(), 32'd0);
    for (int d = 0; d < 2; d++) chk("err_drained", errq[d].size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/veda_ram_2r1w.md
Name: veda_ram_2r1w

Overview:
Parametrised successor to the single-port 32x32 scratch memory. Provides one write port and two independent read ports with registered read data, per-port valid strobes and write-first bypass. A post-reset initialisation sequencer clears every word to a known value, because the array itself has no reset. The block sits beside the datapath as register-file or scratchpad storage.

Parameters:
DATA_W, 32, word width in bits (>=1)
ADDR_W, 5, address width
DEPTH, 32, number of words (2..2**ADDR_W; need not be a power of two)
INIT_VAL, 0, value written to every word during initialisation

Ports:
clk  input  1  clock; all state updates on its rising edge
rst  input  1  asynchronous, active-low reset
ready  output  1  high when initialisation is complete and ports are accepted
wr_en  input  1  write request
wr_addr  input  ADDR_W  write address
wr_data  input  DATA_W  write data
rd0_en  input  1  read request, port 0
rd0_addr  input  ADDR_W  read address, port 0
rd0_data  output  DATA_W  read data, port 0
rd0_valid  output  1  one-cycle strobe: rd0_data holds new data
rd1_en, rd1_addr, rd1_data, rd1_valid  same as port 0, for port 1
addr_err  output  1  one-cycle strobe: an accepted request used an address >= DEPTH
par_err  output  1  parity error strobe (VEDA_PARITY_EN only; tied 0 otherwise)

Behaviour:
- Reset (rst=0, asynchronous): state=INIT, init_ptr=0, ready=0, rd*_valid=0, rd*_data=0, addr_err=0, par_err=0. Array contents are not reset.
- FSM states:
  - INIT: each cycle writes INIT_VAL to mem[init_ptr], then init_ptr increments. Writing the word at init_ptr==DEPTH-1 moves the FSM to RUN.
  - RUN: the FSM stays in RUN until reset.
  - ready=1 only in RUN, so ready rises exactly DEPTH cycles after the first rising edge with rst=1.
- Requests while ready=0 are ignored: no write, no valid, no addr_err.
- Write: with wr_en=1 and ready=1, mem[wr_addr] is updated at the clock edge.
- Read: with rdK_en=1 and ready=1, rdK_data is registered at the next edge and rdK_valid=1 for that cycle (latency 1).
  - With rdK_en=0, rdK_valid=0 and rdK_data holds its last value.
  - Both ports may read the same or different addresses in the same cycle.
- Write-first bypass: a read and a write to the same valid address in the same cycle return wr_data.
- Out-of-range address (>= DEPTH):
  - Write: dropped.
  - Read: returns 0 with rdK_valid=1.
  - addr_err pulses for one cycle if any accepted request in that cycle was out of range (OR of all ports).
- Reset mid-INIT or mid-RUN: FSM returns to INIT with init_ptr=0 and the full clear repeats. Any in-flight read valid is dropped.
- Back-to-back reads and writes are sustained every cycle with no bubbles.

Optional Feature:
VEDA_PARITY_EN:
- Defined:
  - Each word stores one extra even-parity bit, computed on write and during INIT.
  - On each read, parity is rechecked. par_err pulses with the matching rdK_valid when the stored parity mismatches.
  - Bypassed and out-of-range reads never flag.
- Undefined: no parity storage; par_err is constant 0.

Test Plan:
- Release rst, hold all requests, DEPTH=32 -> ready=0 for 32 cycles, then 1; a read of every address returns 0 with rdK_valid one cycle after each request.
- In RUN: write 231 to addr 0, then 423 to addr 1; next cycle rd0 addr 0 and rd1 addr 1 -> rd0_data=231, rd1_data=423, both valid together one cycle later.
- Same cycle: wr addr 5 data 0xDEADBEEF, rd0 addr 5 -> rd0_data=0xDEADBEEF next cycle (bypass); the following read of addr 5 also returns 0xDEADBEEF.
- DEPTH=20: write addr 25 data 7, then read addr 25 -> addr_err pulses on the write and on the read; rd0_data=0; no stored word is changed.
- Write addr 3 = 99, assert rst low for 1 cycle mid-stream, release -> ready low for DEPTH cycles; a subsequent read of addr 3 returns INIT_VAL; wr_en during INIT has no effect.
- VEDA_PARITY_EN: force-flip one stored bit of addr 2 from the bench, then read addr 2 -> par_err=1 with rd0_valid; reads of other addresses leave par_err=0.
